// File: rtl/sr_latch_bank.sv
// sr_latch_bank: clocked bank of independent set/reset cells with conflict
// handling, optional edge-sensitive inputs, enable, clear and conflict stats.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   s, r [CHANNELS]     per-channel set / reset requests
//   en, clr             update enable, synchronous clear (clr wins)
//   q, qbar [CHANNELS]  stored value and its complement
//   conflict [CHANNELS] registered per-channel conflict pulse
//   conflict_cnt [CNT_W] saturating count of edges with any conflict
//   changed             registered: some q bit changed at the last edge
module sr_latch_bank #(
   parameter int unsigned CHANNELS  = 8,
   parameter int unsigned PRIORITY  = 0,
   parameter int unsigned EDGE_MODE = 0,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] s,
   input  logic [CHANNELS-1:0] r,
   input  logic                en,
   input  logic                clr,
   output logic [CHANNELS-1:0] q,
   output logic [CHANNELS-1:0] qbar,
   output logic [CHANNELS-1:0] conflict,
   output logic [CNT_W-1:0]    conflict_cnt,
   output logic                changed
);

   logic [CHANNELS-1:0] q_q, q_d;
   logic [CHANNELS-1:0] s_dly_q, r_dly_q;
   logic [CHANNELS-1:0] conflict_q, conflict_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                changed_q, changed_d;

   logic [CHANNELS-1:0] s_eff, r_eff;
   logic [CHANNELS-1:0] conf_val;
   logic [CHANNELS-1:0] q_upd;
   logic                upd;

   always_comb begin
      s_eff = s;
      r_eff = r;
      if (EDGE_MODE != 0) begin
         s_eff = s & ~s_dly_q;
         r_eff = r & ~r_dly_q;
      end

      // value a cell takes when both requests are active
      unique case (PRIORITY)
         0:       conf_val = '1;
         1:       conf_val = '0;
         2:       conf_val = q_q;
         default: conf_val = ~q_q;
      endcase

      q_upd = (q_q & ~s_eff & ~r_eff)
            | (s_eff & ~r_eff)
            | (s_eff & r_eff & conf_val);

      upd = en & ~clr;

      q_d = q_q;
      if (clr)
         q_d = '0;
      else if (en)
         q_d = q_upd;

      conflict_d = {CHANNELS{upd}} & s_eff & r_eff;

      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (|conflict_d && cnt_q != {CNT_W{1'b1}})
         cnt_d = cnt_q + CNT_W'(1);

      changed_d = |(q_d ^ q_q);
   end

   // input history updates every edge, even when disabled or clearing,
   // so edges seen while en=0 are consumed and never replayed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q        <= '0;
         s_dly_q    <= '0;
         r_dly_q    <= '0;
         conflict_q <= '0;
         cnt_q      <= '0;
         changed_q  <= 1'b0;
      end else begin
         q_q        <= q_d;
         s_dly_q    <= s;
         r_dly_q    <= r;
         conflict_q <= conflict_d;
         cnt_q      <= cnt_d;
         changed_q  <= changed_d;
      end
   end

   assign q            = q_q;
   assign qbar         = ~q_q;
   assign conflict     = conflict_q;
   assign conflict_cnt = cnt_q;
   assign changed      = changed_q;

endmodule

// File: tb/tb_sr_latch_bank.sv
// tb_sr_latch_bank: directed vectors against priority, edge, clear,
// saturation and async-reset behaviour of sr_latch_bank.
module tb_sr_latch_bank;

   logic       clk;
   logic       rst_n;
   logic [3:0] s, r, se, re;
   logic       en, clr;

   logic [3:0] q0, qb0, c0, q1, qb1, c1, q2, qb2, c2, q3, qb3, c3;
   logic [3:0] qs, qbs, cs, qe, qbe, ce;
   logic [7:0] n0, n1, n2, n3, ne;
   logic [1:0] ns;
   logic       ch0, ch1, ch2, ch3, chs, che;

   int checks = 0;
   int errors = 0;

   sr_latch_bank #(.CHANNELS(4), .PRIORITY(0), .EDGE_MODE(0), .CNT_W(8)) u0 (
      .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .clr(clr),
      .q(q0), .qbar(qb0), .conflict(c0), .conflict_cnt(n0), .changed(ch0));
   sr_latch_bank #(.CHANNELS(4), .PRIORITY(1), .EDGE_MODE(0), .CNT_W(8)) u1 (
      .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .clr(clr),
      .q(q1), .qbar(qb1), .conflict(c1), .conflict_cnt(n1), .changed(ch1));
   sr_latch_bank #(.CHANNELS(4), .PRIORITY(2), .EDGE_MODE(0), .CNT_W(8)) u2 (
      .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .clr(clr),
      .q(q2), .qbar(qb2), .conflict(c2), .conflict_cnt(n2), .changed(ch2));
   sr_latch_bank #(.CHANNELS(4), .PRIORITY(3), .EDGE_MODE(0), .CNT_W(8)) u3 (
      .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .clr(clr),
      .q(q3), .qbar(qb3), .conflict(c3), .conflict_cnt(n3), .changed(ch3));
   sr_latch_bank #(.CHANNELS(4), .PRIORITY(0), .EDGE_MODE(0), .CNT_W(2)) us (
      .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .clr(clr),
      .q(qs), .qbar(qbs), .conflict(cs), .conflict_cnt(ns), .changed(chs));
   sr_latch_bank #(.CHANNELS(4), .PRIORITY(0), .EDGE_MODE(1), .CNT_W(8)) ue (
      .clk(clk), .rst_n(rst_n), .s(se), .r(re), .en(en), .clr(clr),
      .q(qe), .qbar(qbe), .conflict(ce), .conflict_cnt(ne), .changed(che));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      s = '0; r = '0; se = '0; re = '0;
      en = 1'b1; clr = 1'b0;
      #3;
      chk("rst_q",    32'(q0),  32'h0);
      chk("rst_qbar", 32'(qb0), 32'hF);
      chk("rst_conf", 32'(c0),  32'h0);
      chk("rst_cnt",  32'(n0),  32'h0);
      chk("rst_chg",  32'(ch0), 32'h0);
      #9 rst_n = 1'b1;

      s = 4'b0001; step();
      chk("set_q",    32'(q0),  32'h1);
      chk("set_qbar", 32'(qb0), 32'hE);
      chk("set_chg",  32'(ch0), 32'h1);
      s = 4'b0000; step();
      chk("hold_q",   32'(q0),  32'h1);
      chk("hold_chg", 32'(ch0), 32'h0);

      s = 4'b0101; r = 4'b1010; step();
      chk("pre_q0", 32'(q0), 32'h5);
      chk("pre_q3", 32'(q3), 32'h5);
      s = 4'b1111; r = 4'b1111; step();
      chk("p0_q",   32'(q0), 32'hF);
      chk("p1_q",   32'(q1), 32'h0);
      chk("p2_q",   32'(q2), 32'h5);
      chk("p3_q",   32'(q3), 32'hA);
      chk("p0_cf",  32'(c0), 32'hF);
      chk("p1_cf",  32'(c1), 32'hF);
      chk("p2_cf",  32'(c2), 32'hF);
      chk("p3_cf",  32'(c3), 32'hF);
      chk("p0_cnt", 32'(n0), 32'h1);
      chk("p1_cnt", 32'(n1), 32'h1);
      chk("p2_cnt", 32'(n2), 32'h1);
      chk("p3_cnt", 32'(n3), 32'h1);
      chk("p2_chg", 32'(ch2), 32'h0);
      chk("p3_qb",  32'(qb3), 32'h5);

      s = '0; r = '0; step();
      chk("idle_cf", 32'(c0), 32'h0);
      chk("idle_cnt", 32'(n0), 32'h1);

      en = 1'b0; s = 4'b1111; r = 4'b1111; step();
      chk("dis_q1",  32'(q1),  32'h0);
      chk("dis_cf",  32'(c1),  32'h0);
      chk("dis_cnt", 32'(n1),  32'h1);
      chk("dis_chg", 32'(ch1), 32'h0);

      en = 1'b1; clr = 1'b1; r = '0; step();
      chk("clr_q0",   32'(q0),  32'h0);
      chk("clr_cnt",  32'(n0),  32'h0);
      chk("clr_chg",  32'(ch0), 32'h1);
      chk("clr_cf",   32'(c0),  32'h0);
      chk("clr_chg1", 32'(ch1), 32'h0);
      chk("clr_cnts", 32'(ns),  32'h0);

      clr = 1'b0; s = 4'b1111; r = 4'b1111;
      step(); chk("sat1", 32'(ns), 32'h1);
      step(); chk("sat2", 32'(ns), 32'h2);
      step(); chk("sat3", 32'(ns), 32'h3);
      step(); chk("sat4", 32'(ns), 32'h3);
      step(); chk("sat5", 32'(ns), 32'h3);
      chk("sat_cf", 32'(cs), 32'hF);
      s = '0; r = '0;

      #2 rst_n = 1'b0;
      #1;
      chk("arst_q",    32'(qs),  32'h0);
      chk("arst_qbar", 32'(qbs), 32'hF);
      chk("arst_cnt",  32'(ns),  32'h0);
      chk("arst_cf",   32'(cs),  32'h0);
      @(negedge clk); rst_n = 1'b1;
      s = 4'b0010; step();
      chk("post_q",   32'(qs),  32'h2);
      chk("post_chg", 32'(chs), 32'h1);
      s = '0;

      se = 4'b0001; step();
      chk("e_set", 32'(qe), 32'h1);
      step();
      chk("e_hold",     32'(qe),  32'h1);
      chk("e_hold_chg", 32'(che), 32'h0);
      step(); step(); step();
      re = 4'b0001; step();
      chk("e_rst", 32'(qe), 32'h0);
      re = 4'b0000; step();
      chk("e_nolvl", 32'(qe), 32'h0);
      step();
      chk("e_nolvl2", 32'(qe), 32'h0);
      se = 4'b0000; step();
      se = 4'b0001; step();
      chk("e_reset", 32'(qe), 32'h1);
      se = 4'b0000; step();
      se = 4'b0001; re = 4'b0001; step();
      chk("e_cf",  32'(ce), 32'h1);
      chk("e_cfq", 32'(qe), 32'h1);
      chk("e_cnt", 32'(ne), 32'h1);
      re = 4'b0000; step();
      en = 1'b0; re = 4'b0001; step();
      chk("e_dis", 32'(qe), 32'h1);
      en = 1'b1; step();
      chk("e_lost", 32'(qe), 32'h1);
      chk("e_lost_cf", 32'(ce), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
